credit_datapath: RTL and testbench

- Parametrised coin-credit datapath for the coffee-machine controller.
- Accumulates coin values into a credit register and compares credit against a configurable price.
- Performs the vend subtraction and returns change as one pulse per credit unit.
- Drives a 7-segment digit showing the current credit. Sits between the coin acceptor and the top-level control FSM; generalises the fixed 3-bit, price-of-3 datapath.

---
 rtl/credit_datapath.sv | 155 +++++++++++++++
 tb/tb_credit_datapath.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/credit_datapath.sv
// Coin-credit datapath: accumulates coins, compares against PRICE, vends, returns change.
// Optional automatic change after a vend: define CREDIT_DATAPATH_AUTO_CHANGE_EN.
module credit_datapath #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned PRICE      = 3,
  parameter int unsigned MAX_CREDIT = 15,
  parameter int unsigned COIN0      = 1,
  parameter int unsigned COIN1      = 2,
  parameter int unsigned COIN2      = 5,
  parameter int unsigned COIN3      = 10
) (
  input  logic             credit_datapath_clock,
  input  logic             credit_datapath_rst,
  input  logic             coin_valid,
  input  logic [1:0]       coin_sel,
  input  logic             clear,
  input  logic             vend_req,
  input  logic             refund_req,
  output logic [WIDTH-1:0] credit,
  output logic             cmp_less,
  output logic             cmp_eql,
  output logic             cmp_grt,
  output logic             busy,
  output logic             vend_ok,
  output logic             coin_reject,
  output logic             change_pulse,
  output logic [6:0]       seg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    REFUND = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] PRICE_W   = WIDTH'(PRICE);
  localparam logic [WIDTH:0]   MAX_W     = (WIDTH + 1)'(MAX_CREDIT);
  localparam logic [WIDTH-1:0] ONE_W     = WIDTH'(1);

  state_t           state;
  logic [WIDTH:0]   coin_value;
  logic [WIDTH:0]   coin_sum;
  logic [3:0]       digit;

  always_comb begin
    case (coin_sel)
      2'd0:    coin_value = (WIDTH + 1)'(COIN0);
      2'd1:    coin_value = (WIDTH + 1)'(COIN1);
      2'd2:    coin_value = (WIDTH + 1)'(COIN2);
      default: coin_value = (WIDTH + 1)'(COIN3);
    endcase
  end

  // One extra bit of headroom so an overshooting coin is seen, not wrapped.
  assign coin_sum = {1'b0, credit} + coin_value;

  always_ff @(posedge credit_datapath_clock) begin
    // NOTE: state and outputs use non-blocking assignments so every branch below
    // sees the pre-edge values of credit and state.
    if (credit_datapath_rst) begin
      state        <= IDLE;
      credit       <= '0;
      vend_ok      <= 1'b0;
      coin_reject  <= 1'b0;
      change_pulse <= 1'b0;
      busy         <= 1'b0;
    end else begin
      vend_ok      <= 1'b0;
      coin_reject  <= 1'b0;
      change_pulse <= 1'b0;
      busy         <= 1'b0;
      if (clear) begin
        state  <= IDLE;
        credit <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (refund_req && credit != '0) begin
              state        <= REFUND;
              busy         <= 1'b1;
              change_pulse <= 1'b1;
              coin_reject  <= coin_valid;
            end else if (vend_req && credit >= PRICE_W) begin
              state       <= VEND;
              credit      <= credit - PRICE_W;
              vend_ok     <= 1'b1;
              busy        <= 1'b1;
              coin_reject <= coin_valid;
            end else if (coin_valid) begin
              if (coin_sum <= MAX_W) credit <= coin_sum[WIDTH-1:0];
              else                   coin_reject <= 1'b1;
            end
          end

          VEND: begin
            coin_reject <= coin_valid;
`ifdef CREDIT_DATAPATH_AUTO_CHANGE_EN
            if (credit != '0) begin
              state        <= REFUND;
              busy         <= 1'b1;
              change_pulse <= 1'b1;
            end else begin
              state <= IDLE;
            end
`else
            state <= IDLE;
`endif
          end

          REFUND: begin
            coin_reject <= coin_valid;
            credit      <= credit - ONE_W;
            if (credit == ONE_W) begin
              state <= IDLE;
            end else begin
              busy         <= 1'b1;
              change_pulse <= 1'b1;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

  assign cmp_less = (credit <  PRICE_W);
  assign cmp_eql  = (credit == PRICE_W);
  assign cmp_grt  = (credit >  PRICE_W);

  assign digit = 4'(credit);

  always_comb begin
    // NOTE: full case with a default keeps this decoder purely combinational.
    case (digit)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      default: seg = 7'h71;
    endcase
  end

endmodule

// File: tb/tb_credit_datapath.sv
// Directed self-checking bench for credit_datapath (default parameters).
// Follows CREDIT_DATAPATH_AUTO_CHANGE_EN the same way as the design.
module tb_credit_datapath;

  logic       clk = 1'b0;
  logic       rst;
  logic       coin_valid;
  logic [1:0] coin_sel;
  logic       clear;
  logic       vend_req;
  logic       refund_req;
  logic [3:0] credit;
  logic       cmp_less, cmp_eql, cmp_grt;
  logic       busy, vend_ok, coin_reject, change_pulse;
  logic [6:0] seg;

  int tests = 0;
  int fails = 0;
  int pulses;

  credit_datapath dut (
    .credit_datapath_clock(clk),
    .credit_datapath_rst  (rst),
    .coin_valid           (coin_valid),
    .coin_sel             (coin_sel),
    .clear                (clear),
    .vend_req             (vend_req),
    .refund_req           (refund_req),
    .credit               (credit),
    .cmp_less             (cmp_less),
    .cmp_eql              (cmp_eql),
    .cmp_grt              (cmp_grt),
    .busy                 (busy),
    .vend_ok              (vend_ok),
    .coin_reject          (coin_reject),
    .change_pulse         (change_pulse),
    .seg                  (seg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are checked there too.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic coin(input logic [1:0] sel);
    coin_valid = 1'b1;
    coin_sel   = sel;
    tick();
    coin_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; coin_valid = 1'b0; coin_sel = 2'd0;
    clear = 1'b0; vend_req = 1'b0; refund_req = 1'b0;
    @(negedge clk);
    tick();
    tick();

    // Reset state
    check("rst_credit", credit, 0);
    check("rst_less", cmp_less, 1);
    check("rst_eql", cmp_eql, 0);
    check("rst_grt", cmp_grt, 0);
    check("rst_seg", seg, 7'h3F);
    check("rst_busy", busy, 0);
    check("rst_vend_ok", vend_ok, 0);
    check("rst_reject", coin_reject, 0);
    check("rst_change", change_pulse, 0);
    rst = 1'b0;
    tick();
    check("post_rst_credit", credit, 0);

    // Back-to-back coins idx0, idx1
    coin_valid = 1'b1; coin_sel = 2'd0;
    tick();
    check("coin0_credit", credit, 1);
    check("coin0_seg", seg, 7'h06);
    coin_sel = 2'd1;
    tick();
    coin_valid = 1'b0;
    check("coin1_credit", credit, 3);
    check("coin1_eql", cmp_eql, 1);
    check("coin1_less", cmp_less, 0);
    check("coin1_seg", seg, 7'h4F);

    // Build to 10, overshoot is rejected, then exactly reach the ceiling
    coin(2'd2);
    coin(2'd1);
    check("ten_credit", credit, 10);
    check("ten_seg", seg, 7'h77);
    coin_valid = 1'b1; coin_sel = 2'd3;
    tick();
    check("over_reject", coin_reject, 1);
    check("over_credit", credit, 10);
    coin_sel = 2'd2;
    tick();
    coin_valid = 1'b0;
    check("max_reject_gone", coin_reject, 0);
    check("max_credit", credit, 15);
    check("max_grt", cmp_grt, 1);
    check("max_seg", seg, 7'h71);

    // Clear from IDLE
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_credit", credit, 0);
    check("clear_less", cmp_less, 1);

    // Vend with credit 5
    coin(2'd2);
    check("vend_pre_credit", credit, 5);
    vend_req = 1'b1;
    tick();
    vend_req = 1'b0;
    check("vend_ok", vend_ok, 1);
    check("vend_credit", credit, 2);
    check("vend_busy", busy, 1);
    check("vend_change", change_pulse, 0);
    tick();
    check("vend_ok_one_cycle", vend_ok, 0);
`ifdef CREDIT_DATAPATH_AUTO_CHANGE_EN
    check("auto_change1", change_pulse, 1);
    check("auto_busy1", busy, 1);
    check("auto_credit1", credit, 2);
    tick();
    check("auto_change2", change_pulse, 1);
    check("auto_busy2", busy, 1);
    check("auto_credit2", credit, 1);
    tick();
    check("auto_change_end", change_pulse, 0);
    check("auto_busy_end", busy, 0);
    check("auto_credit_end", credit, 0);
`else
    check("keep_change", change_pulse, 0);
    check("keep_busy", busy, 0);
    check("keep_credit", credit, 2);
    refund_req = 1'b1;
    tick();
    refund_req = 1'b0;
    check("ref_change1", change_pulse, 1);
    check("ref_busy1", busy, 1);
    check("ref_credit1", credit, 2);
    tick();
    check("ref_change2", change_pulse, 1);
    check("ref_credit2", credit, 1);
    tick();
    check("ref_change_end", change_pulse, 0);
    check("ref_busy_end", busy, 0);
    check("ref_credit_end", credit, 0);
`endif

    // Vend below price is ignored
    coin(2'd1);
    check("low_pre_credit", credit, 2);
    vend_req = 1'b1;
    tick();
    vend_req = 1'b0;
    check("low_vend_ok", vend_ok, 0);
    check("low_busy", busy, 0);
    check("low_credit", credit, 2);
    check("low_reject", coin_reject, 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;

    // Refund of 8 with a coin inserted during REFUND
    coin(2'd2);
    coin(2'd1);
    coin(2'd0);
    check("r8_pre_credit", credit, 8);
    refund_req = 1'b1;
    tick();
    refund_req = 1'b0;
    check("r8_busy", busy, 1);
    pulses = 0;
    for (int i = 0; i < 20 && busy; i++) begin
      if (change_pulse) pulses++;
      coin_valid = (i == 1);
      coin_sel   = 2'd0;
      tick();
      if (i == 1) check("r8_coin_reject", coin_reject, 1);
    end
    coin_valid = 1'b0;
    check("r8_pulses", pulses, 8);
    check("r8_credit_end", credit, 0);
    check("r8_busy_end", busy, 0);

    // Refund of 8 aborted by clear in the third REFUND cycle
    coin(2'd2);
    coin(2'd1);
    coin(2'd0);
    refund_req = 1'b1;
    tick();
    refund_req = 1'b0;
    check("ab_cycle1_credit", credit, 8);
    tick();
    tick();
    check("ab_cycle3_credit", credit, 6);
    check("ab_cycle3_change", change_pulse, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("ab_credit", credit, 0);
    check("ab_busy", busy, 0);
    check("ab_change", change_pulse, 0);
    tick();
    check("ab_stays_idle", busy, 0);
    coin(2'd0);
    check("ab_coin_after", credit, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
